bit_message_printer: RTL and testbench
======================================

Name: bit_message_printer

Overview:
- Parametrised successor to the single-word keyboard-to-RAM printer.
- Assembles ASCII '0'/'1' keystrokes from the UART receiver into WORD_W-bit words and stores up to DEPTH words in an internal buffer.
- On carriage return or buffer full, prints the whole buffer back through the UART transmitter handshake as ASCII binary text, then clears the buffer.
- Sits between uart_rx and uart_tx in the top level.

Parameters:
- WORD_W, 8: bits per stored word; range 1..16.
- DEPTH, 16: words in buffer; range 2..64.
- ADDR_W, $clog2(DEPTH): buffer pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. Asynchronous, active-low: asserts on rst==0, deasserts synchronously to clk.
- rx_data  in  8  received ASCII byte.
- new_rx_data  in  1  one-cycle strobe; rx_data is valid on this cycle.
- tx_busy  in  1  transmitter busy.
- tx_data  out  8  byte to transmit; registered.
- new_tx_data  out  1  one-cycle transmit strobe; registered.
- count  out  ADDR_W+1  stored words, 0..DEPTH.
- busy  out  1  high while printing.
- overrun  out  1  one-cycle pulse when an rx byte is dropped.

Behaviour:
- Reset values: tx_data=0, new_tx_data=0, count=0, busy=0, overrun=0. Also cleared at reset: partial-bit counter, write pointer, read pointer, bit index. State returns to COLLECT.
- COLLECT state, acting on new_rx_data:
  - '0' (0x30) or '1' (0x31): shift the bit into the assembler, MSB first, and increment bit_cnt. When bit_cnt reaches WORD_W, write the word to buf[wr_ptr] in the same cycle, increment wr_ptr and count, and clear bit_cnt.
  - If that write makes count==DEPTH, go to PRINT on the next cycle.
  - 0x0D: discard the partial word (bit_cnt=0). If count>0, go to PRINT; if count==0, stay in COLLECT and emit nothing.
  - 0x1B (ESC): clear count, wr_ptr and bit_cnt.
  - Any other byte is ignored, with no overrun.
- PRINT states: BIT, SEP, then CR and LF when the CRLF feature is enabled.
  - BIT emits buf[rd_ptr][WORD_W-1-idx] as 0x30 or 0x31, for idx = 0..WORD_W-1.
  - SEP emits 0x20 between words only; there is no trailing separator.
  - After the last bit of word count-1, go to CR (feature on) or DONE.
  - DONE: count=0, wr_ptr=0, rd_ptr=0. Returns to COLLECT the next cycle.
  - busy=1 in every state except COLLECT.
- Transmit handshake:
  - A character is issued only in a cycle where tx_busy==0 and new_tx_data was 0 in the previous cycle. The mandatory gap covers the transmitter's one-cycle busy latency.
  - On issue, tx_data is loaded and new_tx_data=1 for exactly one cycle.
  - tx_data holds its value until the next issue.
- new_rx_data during any PRINT or DONE state: the byte is dropped and overrun pulses in the same cycle.
- new_rx_data in the same cycle that the final write triggers PRINT: that byte is the triggering byte and is processed normally.
- Reset mid-print: everything returns immediately to reset values. A strobe already in flight is not completed.
- Buffer: plain register array. Indices wrap modulo DEPTH, but wrap is never reached because count saturates at DEPTH.

Optional Feature:
- Macro BIT_MESSAGE_PRINTER_CRLF_EN.
- When defined: after the last character of a print, emit 0x0D then 0x0A with the same handshake, then DONE.
- When undefined: the CR and LF states do not exist; the last bit character goes straight to DONE.

Decomposition:
- Shared package printer_pkg holds:
  - ASCII constants CH_ZERO, CH_ONE, CH_CR, CH_LF, CH_SP, CH_ESC;
  - the state enum printer_state_t (COLLECT, P_BIT, P_SEP, P_CR, P_LF, DONE).
- One sub-module, tx_issue_gate: generates the issue-enable from tx_busy and the previous-strobe flag, and registers tx_data and new_tx_data.
- Buffer and FSM stay in the top module.

Test Plan (WORD_W=8, DEPTH=4, CRLF enabled unless stated):
- Send "01000001" then 0x0D -> count goes 0->1; tx sequence 0x30,0x31,0x30,0x30,0x30,0x30,0x30,0x31,0x0D,0x0A; count=0 after; busy high throughout the print.
- Send 32 bits with no CR -> auto-print starts after the 32nd bit: 35 characters (words split by 0x20), then CR LF = 37 strobes; no leading or trailing 0x20.
- Hold tx_busy=1 for 20 cycles mid-print -> no new_tx_data during the hold; after release, printing resumes with no character lost or duplicated; strobes are never on consecutive cycles.
- Send 3 bits then 0x0D with count=0 -> no strobes, bit_cnt cleared; a following "11111111",0x0D prints exactly "11111111"+CRLF.
- Send 'A' (0x41) while busy -> overrun pulses for one cycle, buffer unaffected. Send ESC after 2 stored words -> count=0, no print.
- Assert rst=0 for 1 cycle mid-print -> all outputs 0 asynchronously; the next CR with no bits stored produces no output. Repeat with the CRLF macro undefined: output ends at the last bit character.

Source files
------------

// File: rtl/printer_pkg.sv
// printer_pkg: shared definitions for bit_message_printer.
//   - ASCII character constants used by the collector and the printer.
//   - printer_state_t: FSM state encoding (COLLECT, P_BIT, P_SEP, P_CR, P_LF, DONE).
//   - state_char(): maps a printing state (plus the current buffer bit) to the
//     character that state transmits.
package printer_pkg;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_ONE  = 8'h31;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_ESC  = 8'h1B;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        P_BIT   = 3'd1,
        P_SEP   = 3'd2,
        P_CR    = 3'd3,
        P_LF    = 3'd4,
        DONE    = 3'd5
    } printer_state_t;

    // Character emitted by each printing state; non-printing states yield 0.
    function automatic logic [7:0] state_char(printer_state_t s, logic b);
        logic [7:0] c;
        c = 8'h00;
        case (s)
            P_BIT:   c = b ? CH_ONE : CH_ZERO;
            P_SEP:   c = CH_SP;
            P_CR:    c = CH_CR;
            P_LF:    c = CH_LF;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tx_issue_gate.sv
// tx_issue_gate: decides when a character may be handed to the UART
// transmitter and registers the transmit outputs.
//
// Handshake: a character is issued in a cycle where req_i=1, tx_busy_i=0 and
// no strobe was issued in the previous cycle (new_tx_data_o currently 0). The
// enforced idle cycle covers the transmitter's one-cycle busy latency, so
// strobes are never back to back. On issue, tx_data_o is loaded with char_i
// and new_tx_data_o is high for exactly the following cycle; tx_data_o then
// holds until the next issue.
//
// Ports:
//   clk           in   clock
//   rst           in   asynchronous active-low reset
//   tx_busy_i     in   transmitter busy
//   req_i         in   a character is waiting to be sent
//   char_i        in   character to send
//   fire_o        out  the character is taken this cycle
//   tx_data_o     out  registered transmit byte
//   new_tx_data_o out  registered one-cycle transmit strobe
module tx_issue_gate (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_busy_i,
    input  logic       req_i,
    input  logic [7:0] char_i,
    output logic       fire_o,
    output logic [7:0] tx_data_o,
    output logic       new_tx_data_o
);

    logic [7:0] tx_data_q;
    logic       new_tx_data_q;
    logic       issue_en;

    assign issue_en      = !tx_busy_i && !new_tx_data_q;
    assign fire_o        = req_i && issue_en;
    assign tx_data_o     = tx_data_q;
    assign new_tx_data_o = new_tx_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
        end else begin
            new_tx_data_q <= fire_o;
            if (fire_o) begin
                tx_data_q <= char_i;
            end
        end
    end

endmodule

// File: rtl/bit_message_printer.sv
// bit_message_printer: collects ASCII '0'/'1' keystrokes from the UART
// receiver into WORD_W-bit words (MSB first), stores up to DEPTH words, and on
// carriage return or a full buffer prints the whole buffer back as ASCII
// binary text with a space between words, then clears the buffer.
//
// Build option: define BIT_MESSAGE_PRINTER_CRLF_EN to append CR LF after the
// last printed character. Without it, printing ends at the last bit character.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-low reset
//   rx_data      in   received ASCII byte
//   new_rx_data  in   one-cycle strobe qualifying rx_data
//   tx_busy      in   transmitter busy
//   tx_data      out  byte to transmit (registered)
//   new_tx_data  out  one-cycle transmit strobe (registered)
//   count        out  stored words, 0..DEPTH
//   busy         out  high in every state except COLLECT
//   overrun      out  pulses when an rx byte arrives while printing and is dropped
module bit_message_printer
    import printer_pkg::*;
#(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     new_rx_data,
    input  logic                     tx_busy,
    output logic [7:0]               tx_data,
    output logic                     new_tx_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     overrun
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [ADDR_W:0]  FULL     = (ADDR_W + 1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

    printer_state_t    state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              wr_en;
    logic [WORD_W-1:0] shift_word;
    logic [WORD_W-1:0] rd_word;
    logic              rd_bit;
    logic              tx_req;
    logic              tx_fire;
    logic [7:0]        tx_char;
    logic              is_bit_char;

    // The incoming bit lands in the LSB; after WORD_W shifts the first key
    // typed sits in the MSB. Stale bits of a discarded partial word are
    // shifted out before the next full word is written.
    assign is_bit_char = (rx_data == CH_ZERO) || (rx_data == CH_ONE);
    assign shift_word  = (shreg_q << 1) | WORD_W'(rx_data == CH_ONE);

    assign rd_word = mem_q[rd_ptr_q];
    assign rd_bit  = rd_word[LAST_IDX - idx_q];
    assign tx_req  = (state_q == P_BIT) || (state_q == P_SEP) ||
                     (state_q == P_CR)  || (state_q == P_LF);
    assign tx_char = state_char(state_q, rd_bit);

    assign busy    = (state_q != COLLECT);
    assign overrun = new_rx_data && busy;
    assign count   = count_q;

    tx_issue_gate u_gate (
        .clk           (clk),
        .rst           (rst),
        .tx_busy_i     (tx_busy),
        .req_i         (tx_req),
        .char_i        (tx_char),
        .fire_o        (tx_fire),
        .tx_data_o     (tx_data),
        .new_tx_data_o (new_tx_data)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        wr_en     = 1'b0;

        case (state_q)
            COLLECT: begin
                if (new_rx_data) begin
                    if (is_bit_char) begin
                        shreg_d = shift_word;
                        if (bit_cnt_q == LAST_IDX) begin
                            bit_cnt_d = '0;
                            wr_en     = 1'b1;
                            wr_ptr_d  = wr_ptr_q + 1'b1;
                            count_d   = count_q + 1'b1;
                            if (count_q + 1'b1 == FULL) begin
                                state_d = P_BIT;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else if (rx_data == CH_CR) begin
                        bit_cnt_d = '0;
                        if (count_q != '0) begin
                            state_d = P_BIT;
                        end
                    end else if (rx_data == CH_ESC) begin
                        count_d   = '0;
                        wr_ptr_d  = '0;
                        bit_cnt_d = '0;
                    end
                end
            end

            P_BIT: begin
                if (tx_fire) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if ({1'b0, rd_ptr_q} == count_q - 1'b1) begin
`ifdef BIT_MESSAGE_PRINTER_CRLF_EN
                            state_d = P_CR;
`else
                            state_d = DONE;
`endif
                        end else begin
                            rd_ptr_d = rd_ptr_q + 1'b1;
                            state_d  = P_SEP;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            P_SEP: begin
                if (tx_fire) begin
                    state_d = P_BIT;
                end
            end

`ifdef BIT_MESSAGE_PRINTER_CRLF_EN
            P_CR: begin
                if (tx_fire) begin
                    state_d = P_LF;
                end
            end

            P_LF: begin
                if (tx_fire) begin
                    state_d = DONE;
                end
            end
`endif

            DONE: begin
                count_d  = '0;
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                idx_d    = '0;
                state_d  = COLLECT;
            end

            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= COLLECT;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            idx_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            idx_q     <= idx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Buffer contents need no reset: count and the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_word;
        end
    end

endmodule

// File: tb/tb_bit_message_printer.sv
// tb_bit_message_printer: directed test of bit_message_printer with
// WORD_W=8, DEPTH=4. Expected transmit characters are pushed into exp_q when
// the keystrokes are driven and popped when the DUT strobes new_tx_data.
// A small transmitter model raises tx_busy one cycle after each strobe.
// Expectations follow BIT_MESSAGE_PRINTER_CRLF_EN when it is defined.
module tb_bit_message_printer;
    import printer_pkg::*;

    localparam int WORD_W = 8;
    localparam int DEPTH  = 4;
`ifdef BIT_MESSAGE_PRINTER_CRLF_EN
    localparam int NCRLF = 2;
`else
    localparam int NCRLF = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       new_rx_data;
    logic       tx_busy;
    logic       hold_busy;
    logic       model_busy;
    logic [7:0] tx_data;
    logic       new_tx_data;
    logic [2:0] count;
    logic       busy;
    logic       overrun;

    int n_cmp    = 0;
    int n_err    = 0;
    int n_strobe = 0;
    logic [7:0] exp_q[$];
    logic prev_strobe = 1'b0;
    logic prev_busy   = 1'b0;

    assign tx_busy = hold_busy | model_busy;

    bit_message_printer #(.WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .count       (count),
        .busy        (busy),
        .overrun     (overrun)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- transmitter model ----------------
    initial begin
        model_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && new_tx_data) begin
                @(posedge clk);
                #1 model_busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 model_busy = 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst && new_tx_data) begin
                int qs;
                qs = exp_q.size();
                n_strobe++;
                check("strobe_gap", {31'd0, prev_strobe}, 32'd0);
                check("strobe_while_busy", {31'd0, prev_busy}, 32'd0);
                check("busy_in_print", {31'd0, busy}, 32'd1);
                check("exp_q_nonempty", {31'd0, (qs > 0)}, 32'd1);
                if (qs > 0) begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("tx_char", {24'd0, tx_data}, {24'd0, e});
                end
            end
            prev_strobe = rst && new_tx_data;
            prev_busy   = tx_busy;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data     = b;
        new_rx_data = 1'b1;
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
    endtask

    task automatic send_word(input logic [WORD_W-1:0] w);
        for (int i = WORD_W - 1; i >= 0; i--) begin
            send_byte(w[i] ? CH_ONE : CH_ZERO);
        end
    endtask

    task automatic push_word(input logic [WORD_W-1:0] w);
        for (int i = WORD_W - 1; i >= 0; i--) begin
            exp_q.push_back(w[i] ? CH_ONE : CH_ZERO);
        end
    endtask

    task automatic push_crlf();
`ifdef BIT_MESSAGE_PRINTER_CRLF_EN
        exp_q.push_back(CH_CR);
        exp_q.push_back(CH_LF);
`endif
    endtask

    task automatic wait_idle(input string tag);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        check(tag, {31'd0, done}, 32'd1);
    endtask

    // Drive one rx byte and check overrun in its cycle and the cycle after.
    task automatic pulse_rx_check(input string tag, input logic [7:0] b, input logic exp_ov);
        @(posedge clk);
        #1;
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        check(tag, {31'd0, overrun}, {31'd0, exp_ov});
        @(posedge clk);
        #1;
        new_rx_data = 1'b0;
        @(negedge clk);
        check({tag, "_after"}, {31'd0, overrun}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int s0;
        logic [WORD_W-1:0] w;
        logic done;

        rst         = 1'b0;
        rx_data     = 8'h00;
        new_rx_data = 1'b0;
        hold_busy   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_new_tx_data", {31'd0, new_tx_data}, 32'd0);
        check("rst_count", {29'd0, count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // Single word then CR
        w = 8'b0100_0001;
        push_word(w);
        push_crlf();
        for (int i = WORD_W - 1; i >= 1; i--) send_byte(w[i] ? CH_ONE : CH_ZERO);
        check("t1_count_partial", {29'd0, count}, 32'd0);
        send_byte(w[0] ? CH_ONE : CH_ZERO);
        check("t1_count_one", {29'd0, count}, 32'd1);
        s0 = n_strobe;
        send_byte(CH_CR);
        check("t1_busy_start", {31'd0, busy}, 32'd1);
        wait_idle("t1_finish");
        check("t1_count_after", {29'd0, count}, 32'd0);
        check("t1_strobes", n_strobe - s0, 32'(WORD_W + NCRLF));

        // Four random words, auto-print on full, tx_busy hold mid-print
        s0 = n_strobe;
        for (int k = 0; k < DEPTH; k++) begin
            w = WORD_W'($urandom_range(0, 255));
            if (k > 0) exp_q.push_back(CH_SP);
            push_word(w);
            send_word(w);
        end
        push_crlf();
        check("t2_busy_autoprint", {31'd0, busy}, 32'd1);
        check("t2_count_full", {29'd0, count}, 32'(DEPTH));
        repeat (40) @(posedge clk);
        #1 hold_busy = 1'b1;
        begin
            int sh;
            sh = n_strobe;
            repeat (20) @(posedge clk);
            check("t2_hold_quiet", {31'd0, (n_strobe - sh <= 1)}, 32'd1);
        end
        #1 hold_busy = 1'b0;
        wait_idle("t2_finish");
        check("t2_strobes", n_strobe - s0, 32'(DEPTH * WORD_W + DEPTH - 1 + NCRLF));
        check("t2_count_after", {29'd0, count}, 32'd0);

        // Partial word discarded by CR with empty buffer
        s0 = n_strobe;
        send_byte(CH_ONE);
        send_byte(CH_ONE);
        send_byte(CH_ZERO);
        send_byte(CH_CR);
        repeat (10) @(negedge clk);
        check("t3_no_strobe", n_strobe - s0, 32'd0);
        check("t3_busy", {31'd0, busy}, 32'd0);
        check("t3_count", {29'd0, count}, 32'd0);
        push_word(8'hFF);
        push_crlf();
        send_word(8'hFF);
        check("t3_count_one", {29'd0, count}, 32'd1);
        send_byte(CH_CR);
        wait_idle("t3_finish");
        check("t3_strobes", n_strobe - s0, 32'(WORD_W + NCRLF));

        // Ignored byte in COLLECT, overrun while printing
        pulse_rx_check("t4_ignore_ov", 8'h41, 1'b0);
        check("t4_ignore_count", {29'd0, count}, 32'd0);
        push_word(8'hA5);
        push_crlf();
        send_word(8'hA5);
        send_byte(CH_CR);
        repeat (5) @(posedge clk);
        pulse_rx_check("t4_overrun_A", 8'h41, 1'b1);
        pulse_rx_check("t4_overrun_bit", CH_ONE, 1'b1);
        wait_idle("t4_finish");
        check("t4_count_after", {29'd0, count}, 32'd0);

        // ESC after two words, then a fresh word lands at slot 0
        send_word(8'h12);
        send_word(8'h34);
        check("t5_count_two", {29'd0, count}, 32'd2);
        send_byte(CH_ESC);
        check("t5_count_esc", {29'd0, count}, 32'd0);
        check("t5_busy_esc", {31'd0, busy}, 32'd0);
        s0 = n_strobe;
        send_byte(CH_CR);
        repeat (20) @(negedge clk);
        check("t5_no_strobe", n_strobe - s0, 32'd0);
        push_word(8'h5A);
        push_crlf();
        send_word(8'h5A);
        send_byte(CH_CR);
        wait_idle("t5_finish");

        // Reset mid-print
        push_word(8'hC3);
        push_crlf();
        send_word(8'hC3);
        s0 = n_strobe;
        send_byte(CH_CR);
        done = 1'b0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (n_strobe >= s0 + 3) done = 1'b1;
        end
        check("t6_reached_mid", {31'd0, done}, 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("t6_rst_new_tx_data", {31'd0, new_tx_data}, 32'd0);
        check("t6_rst_count", {29'd0, count}, 32'd0);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        s0 = n_strobe;
        send_byte(CH_CR);
        repeat (20) @(negedge clk);
        check("t6_no_strobe", n_strobe - s0, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
